// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer: FSM states, BCD digit
// limits and the preset range check.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_e;

    localparam int         DIGIT_W      = 4;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

    // A preset is loadable only if every digit is a real BCD digit in range.
    function automatic logic preset_ok(input logic [7:0] min_bcd,
                                       input logic [7:0] sec_bcd,
                                       input logic [3:0] min_tens_max);
        return (min_bcd[7:4] <= min_tens_max) && (min_bcd[3:0] <= DIGIT_MAX) &&
               (sec_bcd[7:4] <= SEC_TENS_MAX) && (sec_bcd[3:0] <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_mmss_dec.sv
// Combinational one-second decrement of a BCD MM:SS value with a zero flag.
// The result at 00:00 is meaningless; callers gate with zero_o.
module bcd_mmss_dec
    import timer_pkg::*;
(
    input  logic [15:0] mmss_i,
    output logic [15:0] mmss_o,
    output logic        zero_o
);

    logic [DIGIT_W-1:0] min_t, min_o, sec_t, sec_o;

    always_comb begin
        {min_t, min_o, sec_t, sec_o} = mmss_i;
        if (sec_o != 4'd0) begin
            sec_o = sec_o - 4'd1;
        end else begin
            sec_o = DIGIT_MAX;
            if (sec_t != 4'd0) begin
                sec_t = sec_t - 4'd1;
            end else begin
                sec_t = SEC_TENS_MAX;
                if (min_o != 4'd0) begin
                    min_o = min_o - 4'd1;
                end else begin
                    min_o = DIGIT_MAX;
                    min_t = min_t - 4'd1;
                end
            end
        end
        mmss_o = {min_t, min_o, sec_t, sec_o};
        zero_o = (mmss_i == 16'h0000);
    end

endmodule

// File: rtl/countdown_sequencer.sv
// MM:SS countdown controller: loads a BCD preset, counts down on 1 Hz ticks,
// gates the frequency divider and drives the post-expiry alarm window.
module countdown_sequencer
    import timer_pkg::*;
#(
    parameter int ALARM_TICKS  = 5,
    parameter int MAX_MIN_TENS = 5
) (
    input  logic       C50,
    input  logic       reset_n,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic [7:0] preset_min,
    input  logic [7:0] preset_sec,
    input  logic       tick,
    output logic       div_clr,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       alarm,
    output logic       preset_err
);

    localparam int CNT_W = $clog2(ALARM_TICKS + 1);

    state_e             state_q, state_d;
    logic [7:0]         min_q, min_d, sec_q, sec_d;
    logic               alarm_q, alarm_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [15:0]        dec_mmss;
    logic               cur_zero;
    logic               load_ok, load_zero;

    bcd_mmss_dec u_dec (
        .mmss_i (16'({min_q, sec_q})),
        .mmss_o (dec_mmss),
        .zero_o (cur_zero)
    );

    assign load_ok   = preset_ok(preset_min, preset_sec, 4'(MAX_MIN_TENS));
    assign load_zero = ({preset_min, preset_sec} == 16'h0000);

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        alarm_d = alarm_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            min_d   = 8'h00;
            sec_d   = 8'h00;
            alarm_d = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (load_ok) begin
                            min_d   = preset_min;
                            sec_d   = preset_sec;
                            alarm_d = 1'b0;
                            cnt_d   = '0;
                            state_d = load_zero ? ST_DONE : ST_RUN;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (state_q == ST_DONE && tick && alarm_q) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_d == CNT_W'(ALARM_TICKS)) alarm_d = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (tick && !cur_zero) begin
                        {min_d, sec_d} = dec_mmss;
                        // Expiry lands in DONE on the same update that reaches 00:00.
                        if (dec_mmss == 16'h0000) begin
                            state_d = ST_DONE;
                            alarm_d = 1'b1;
                            cnt_d   = '0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start) state_d = ST_RUN;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge C50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            min_q   <= 8'h00;
            sec_q   <= 8'h00;
            alarm_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            alarm_q <= alarm_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Divider runs only in RUN and DONE so each counted second is a full period.
    assign div_clr    = (state_q == ST_IDLE) || (state_q == ST_PAUSE);
    assign running    = (state_q == ST_RUN);
    assign min_bcd    = min_q;
    assign sec_bcd    = sec_q;
    assign alarm      = alarm_q;
    assign preset_err = err_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Self-checking bench for countdown_sequencer; tick results are scored
// against an independent seconds-count model through an expected-value queue.
module tb_countdown_sequencer;

    logic       C50 = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0, pause = 1'b0, clear = 1'b0, tick = 1'b0;
    logic [7:0] preset_min = 8'h00, preset_sec = 8'h00;
    logic       div_clr, running, alarm, preset_err;
    logic [7:0] min_bcd, sec_bcd;

    int          errors = 0;
    int          checks = 0;
    int          model_s;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;

    countdown_sequencer #(.ALARM_TICKS(5), .MAX_MIN_TENS(5)) dut (
        .C50        (C50),
        .reset_n    (reset_n),
        .start      (start),
        .pause      (pause),
        .clear      (clear),
        .preset_min (preset_min),
        .preset_sec (preset_sec),
        .tick       (tick),
        .div_clr    (div_clr),
        .min_bcd    (min_bcd),
        .sec_bcd    (sec_bcd),
        .running    (running),
        .alarm      (alarm),
        .preset_err (preset_err)
    );

    always #10 C50 = ~C50;

    function automatic logic [15:0] to_bcd(input int secs);
        int m, s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // Inputs change on the falling edge; outputs are read on the next falling edge.
    task automatic drive(input logic st, input logic ps, input logic cl, input logic tk);
        start = st; pause = ps; clear = cl; tick = tk;
        @(negedge C50);
        start = 1'b0; pause = 1'b0; clear = 1'b0; tick = 1'b0;
    endtask

    task automatic load_start(input logic [7:0] m, input logic [7:0] s);
        preset_min = m;
        preset_sec = s;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick_push();
        model_s = model_s - 1;
        exp_q.push_back(to_bcd(model_s));
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        @(negedge C50);
        reset_n = 1'b0;
        drive(0, 0, 0, 0);
        reset_n = 1'b1;
        drive(0, 0, 0, 0);
        checks++;
        if ({min_bcd, sec_bcd} !== 16'h0000) begin
            errors++; $display("FAIL reset_digits: got %h want 0000", {min_bcd, sec_bcd});
        end
        checks++;
        if ({div_clr, running, alarm, preset_err} !== 4'b1000) begin
            errors++; $display("FAIL reset_flags: got %b want 1000", {div_clr, running, alarm, preset_err});
        end
        load_start(8'h01, 8'h30);
        checks++;
        if ({running, min_bcd, sec_bcd} !== {1'b1, 16'h0130}) begin
            errors++; $display("FAIL reset_preload: got %h want 10130", {running, min_bcd, sec_bcd});
        end
        #5 reset_n = 1'b0;
        #1;
        checks++;
        if ({min_bcd, sec_bcd, div_clr, running} !== {16'h0000, 2'b10}) begin
            errors++; $display("FAIL reset_async: got %h want %h", {min_bcd, sec_bcd, div_clr, running}, {16'h0000, 2'b10});
        end
        @(negedge C50);
        reset_n = 1'b1;
        drive(0, 0, 0, 0);
    endtask

    task automatic test_run();
        load_start(8'h01, 8'h00);
        model_s = 60;
        checks++;
        if ({running, div_clr} !== 2'b10) begin
            errors++; $display("FAIL run_flags: got %b want 10", {running, div_clr});
        end
        for (int i = 0; i < 3; i++) begin
            tick_push();
            exp_v = exp_q.pop_front();
            checks++;
            if ({min_bcd, sec_bcd} !== exp_v) begin
                errors++; $display("FAIL run_tick%0d: got %h want %h", i, {min_bcd, sec_bcd}, exp_v);
            end
        end
        drive(0, 0, 1, 0);
    endtask

    task automatic test_expiry();
        load_start(8'h00, 8'h02);
        model_s = 2;
        for (int i = 0; i < 2; i++) begin
            tick_push();
            exp_v = exp_q.pop_front();
            checks++;
            if ({min_bcd, sec_bcd} !== exp_v) begin
                errors++; $display("FAIL exp_tick%0d: got %h want %h", i, {min_bcd, sec_bcd}, exp_v);
            end
        end
        checks++;
        if ({alarm, running, div_clr} !== 3'b100) begin
            errors++; $display("FAIL exp_done: got %b want 100", {alarm, running, div_clr});
        end
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 0, 1);
            checks++;
            if (alarm !== (k < 5)) begin
                errors++; $display("FAIL exp_alarm%0d: got %b want %b", k, alarm, (k < 5));
            end
        end
        drive(0, 0, 0, 1);
        checks++;
        if ({alarm, min_bcd, sec_bcd} !== 17'h0) begin
            errors++; $display("FAIL exp_after: got %h want 0", {alarm, min_bcd, sec_bcd});
        end
        load_start(8'h00, 8'h01);
        drive(0, 0, 0, 1);
        load_start(8'h00, 8'h03);
        checks++;
        if ({alarm, running, min_bcd, sec_bcd} !== {2'b01, 16'h0003}) begin
            errors++; $display("FAIL exp_reload: got %h want %h", {alarm, running, min_bcd, sec_bcd}, {2'b01, 16'h0003});
        end
        drive(0, 0, 1, 0);
    endtask

    task automatic test_pause();
        load_start(8'h00, 8'h45);
        model_s = 45;
        drive(0, 1, 0, 0);
        checks++;
        if ({running, div_clr, min_bcd, sec_bcd} !== {2'b01, 16'h0045}) begin
            errors++; $display("FAIL pause_enter: got %h want %h", {running, div_clr, min_bcd, sec_bcd}, {2'b01, 16'h0045});
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1);
            checks++;
            if ({div_clr, min_bcd, sec_bcd} !== {1'b1, 16'h0045}) begin
                errors++; $display("FAIL pause_hold%0d: got %h want %h", i, {div_clr, min_bcd, sec_bcd}, {1'b1, 16'h0045});
            end
        end
        drive(1, 0, 0, 0);
        checks++;
        if ({running, div_clr} !== 2'b10) begin
            errors++; $display("FAIL pause_resume: got %b want 10", {running, div_clr});
        end
        tick_push();
        exp_v = exp_q.pop_front();
        checks++;
        if ({min_bcd, sec_bcd} !== exp_v) begin
            errors++; $display("FAIL pause_tick: got %h want %h", {min_bcd, sec_bcd}, exp_v);
        end
        drive(0, 1, 0, 0);
        drive(1, 1, 0, 0);
        checks++;
        if (running !== 1'b1) begin
            errors++; $display("FAIL pause_start_wins: got %b want 1", running);
        end
        drive(0, 0, 1, 0);
    endtask

    task automatic test_invalid();
        logic [15:0] bad [3];
        bad[0] = 16'h0075; bad[1] = 16'h6A00; bad[2] = 16'h6000;
        for (int i = 0; i < 3; i++) begin
            load_start(bad[i][15:8], bad[i][7:0]);
            checks++;
            if ({preset_err, running, div_clr, min_bcd, sec_bcd} !== {3'b101, 16'h0000}) begin
                errors++; $display("FAIL inv_%h: got %h want %h", bad[i], {preset_err, running, div_clr, min_bcd, sec_bcd}, {3'b101, 16'h0000});
            end
            drive(0, 0, 0, 0);
            checks++;
            if (preset_err !== 1'b0) begin
                errors++; $display("FAIL inv_pulse_%h: got %b want 0", bad[i], preset_err);
            end
        end
        load_start(8'h59, 8'h59);
        checks++;
        if ({preset_err, running, min_bcd, sec_bcd} !== {2'b01, 16'h5959}) begin
            errors++; $display("FAIL inv_max_ok: got %h want %h", {preset_err, running, min_bcd, sec_bcd}, {2'b01, 16'h5959});
        end
        drive(0, 0, 1, 0);
    endtask

    task automatic test_simultaneous();
        load_start(8'h10, 8'h00);
        drive(0, 0, 1, 1);
        checks++;
        if ({running, div_clr, min_bcd, sec_bcd} !== {2'b01, 16'h0000}) begin
            errors++; $display("FAIL sim_clear_tick: got %h want %h", {running, div_clr, min_bcd, sec_bcd}, {2'b01, 16'h0000});
        end
        load_start(8'h10, 8'h00);
        model_s = 600;
        drive(0, 1, 0, 1);
        checks++;
        if ({running, div_clr, min_bcd, sec_bcd} !== {2'b01, 16'h1000}) begin
            errors++; $display("FAIL sim_pause_tick: got %h want %h", {running, div_clr, min_bcd, sec_bcd}, {2'b01, 16'h1000});
        end
        drive(1, 0, 0, 0);
        tick_push();
        exp_v = exp_q.pop_front();
        checks++;
        if ({min_bcd, sec_bcd} !== exp_v) begin
            errors++; $display("FAIL sim_borrow: got %h want %h", {min_bcd, sec_bcd}, exp_v);
        end
        load_start(8'h05, 8'h00);
        checks++;
        if ({running, preset_err, min_bcd, sec_bcd} !== {2'b10, exp_v}) begin
            errors++; $display("FAIL sim_start_in_run: got %h want %h", {running, preset_err, min_bcd, sec_bcd}, {2'b10, exp_v});
        end
        drive(0, 0, 1, 0);
    endtask

    initial begin
        test_reset();
        test_run();
        test_expiry();
        test_pause();
        test_invalid();
        test_simultaneous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
